// File: rtl/maxpool_layer_ctrl_pkg.sv
// rtl/maxpool_layer_ctrl_pkg.sv - shared codes and state types for the maxpool layer sequencer
package maxpool_layer_ctrl_pkg;

  localparam logic [3:0] ST_IDLE = 4'b0000;
  localparam logic [3:0] ST_BUSY = 4'b0001;
  localparam logic [3:0] ST_ERR  = 4'b1110;
  localparam logic [3:0] ST_DONE = 4'b1111;

  localparam logic [3:0] SW_RESHAPE = 4'b1000;
  localparam logic [3:0] OP_MAXPOOL = 4'b0100;
  localparam logic [3:0] OP_ACK     = 4'b1111;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_CFG,
    FSM_RUN,
    FSM_DONE,
    FSM_ERR
  } ctrl_state_t;

  // Channel units are 32 channels each; beats per pixel is a pure left shift.
  function automatic int cpp_shift(input int ch_per_beat);
    return 5 - $clog2(ch_per_beat);
  endfunction

endpackage

// File: rtl/maxpool_layer_ctrl_if.sv
// rtl/maxpool_layer_ctrl_if.sv - DMA/datapath start, pool config and stream snoop bundle
interface maxpool_layer_ctrl_if #(
  parameter int WIDTH_FEATURE_SIZE = 12
);
  logic                          DMA_Read_Start;
  logic                          DMA_Write_Start;
  logic                          pool_start;
  logic [WIDTH_FEATURE_SIZE-1:0] pool_row_width;
  logic [15:0]                   pool_beats_per_pix;
  logic                          S_Valid;
  logic                          S_Ready;
  logic                          M_Valid;
  logic                          M_Ready;

  modport master (
    output DMA_Read_Start, DMA_Write_Start, pool_start, pool_row_width, pool_beats_per_pix,
    input  S_Valid, S_Ready, M_Valid, M_Ready
  );

  modport slave (
    input  DMA_Read_Start, DMA_Write_Start, pool_start, pool_row_width, pool_beats_per_pix,
    output S_Valid, S_Ready, M_Valid, M_Ready
  );
endinterface

// File: rtl/maxpool_layer_ctrl_beat_counter.sv
// rtl/maxpool_layer_ctrl_beat_counter.sv - beat counter that stops at its limit and flags equality
module maxpool_layer_ctrl_beat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  assign hit = (count == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !hit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/maxpool_layer_ctrl.sv
// rtl/maxpool_layer_ctrl.sv - ReShape-path 2x2 maxpool layer sequencer
module maxpool_layer_ctrl
  import maxpool_layer_ctrl_pkg::*;
#(
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10,
  parameter int CH_PER_BEAT        = 16,
  parameter int CNT_W              = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          Switch,
  input  logic [7:0]          Control_RE,
  input  logic [31:0]         Reg_7,
  output logic [3:0]          State_RE,
  output logic                irq_done,
  maxpool_layer_ctrl_if.master dp
);

  localparam int CPP_SHIFT = cpp_shift(CH_PER_BEAT);

  ctrl_state_t                   state, state_d;
  logic [WIDTH_FEATURE_SIZE-1:0] w_q;
  logic [WIDTH_CHANNEL_NUM-1:0]  u_q;
  logic [CNT_W-1:0]              in_total, out_total, in_cnt, out_cnt;
  logic [CNT_W-1:0]              w_ext, half_w, cpp;
  logic                          start_pulse, in_hit, out_hit;
  logic                          start_cmd, ack_cmd, cfg_bad;
  logic                          unused_bits;

  assign start_cmd = (Switch == SW_RESHAPE) && (Control_RE[3:0] == OP_MAXPOOL);
  assign ack_cmd   = (Control_RE[3:0] == OP_ACK);
  assign cfg_bad   = (w_q == '0) || w_q[0] || (u_q == '0);
  assign w_ext     = CNT_W'(w_q);
  assign half_w    = CNT_W'(w_q >> 1);
  assign cpp       = CNT_W'(u_q) << CPP_SHIFT;

  assign unused_bits = ^{Control_RE[7:4], Reg_7, in_cnt, in_hit};

  always_comb begin
    state_d = state;
    case (state)
      FSM_IDLE: if (start_cmd) state_d = FSM_CFG;
      FSM_CFG:  state_d = cfg_bad ? FSM_ERR : FSM_RUN;
      FSM_RUN:  if (out_hit) state_d = FSM_DONE;
      FSM_DONE: if (ack_cmd) state_d = FSM_IDLE;
      FSM_ERR:  if (ack_cmd) state_d = FSM_IDLE;
      default:  state_d = FSM_IDLE;
    endcase
  end

  always_comb begin
    State_RE = ST_IDLE;
    case (state)
      FSM_CFG, FSM_RUN: State_RE = ST_BUSY;
      FSM_DONE:         State_RE = ST_DONE;
      FSM_ERR:          State_RE = ST_ERR;
      default:          State_RE = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= FSM_IDLE;
      w_q                   <= '0;
      u_q                   <= '0;
      in_total              <= '0;
      out_total             <= '0;
      start_pulse           <= 1'b0;
      irq_done              <= 1'b0;
      dp.pool_row_width     <= '0;
      dp.pool_beats_per_pix <= '0;
    end else begin
      state       <= state_d;
      start_pulse <= 1'b0;
      irq_done    <= (state == FSM_RUN && out_hit) || (state == FSM_CFG && cfg_bad);
      if (state == FSM_IDLE && start_cmd) begin
        w_q <= Reg_7[WIDTH_FEATURE_SIZE-1:0];
        u_q <= Reg_7[16 +: WIDTH_CHANNEL_NUM];
      end
      // Totals are only consumed in RUN, so registering them at the CFG edge is enough.
      if (state == FSM_CFG && !cfg_bad) begin
        in_total              <= w_ext * w_ext * cpp;
        out_total             <= half_w * half_w * cpp;
        start_pulse           <= 1'b1;
        dp.pool_row_width     <= w_q;
        dp.pool_beats_per_pix <= 16'(cpp);
      end
    end
  end

  assign dp.DMA_Read_Start  = start_pulse;
  assign dp.DMA_Write_Start = start_pulse;
  assign dp.pool_start      = start_pulse;

  maxpool_layer_ctrl_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state == FSM_RUN && dp.S_Valid && dp.S_Ready),
    .clr   (state == FSM_IDLE && start_cmd),
    .limit (in_total),
    .count (in_cnt),
    .hit   (in_hit)
  );

  maxpool_layer_ctrl_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state == FSM_RUN && dp.M_Valid && dp.M_Ready),
    .clr   (state == FSM_IDLE && start_cmd),
    .limit (out_total),
    .count (out_cnt),
    .hit   (out_hit)
  );

endmodule

// File: tb/tb_maxpool_layer_ctrl.sv
// tb/tb_maxpool_layer_ctrl.sv - directed self-checking bench for the maxpool layer sequencer
module tb_maxpool_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  Switch = '0;
  logic [7:0]  Control_RE = '0;
  logic [31:0] Reg_7 = '0;
  logic [3:0]  State_RE;
  logic        irq_done;

  int tests_run = 0;
  int tests_failed = 0;
  int rd_cnt = 0, wr_cnt = 0, ps_cnt = 0, irq_cnt = 0;

  maxpool_layer_ctrl_if dp ();

  maxpool_layer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .Switch     (Switch),
    .Control_RE (Control_RE),
    .Reg_7      (Reg_7),
    .State_RE   (State_RE),
    .irq_done   (irq_done),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dp.DMA_Read_Start)  rd_cnt = rd_cnt + 1;
    if (dp.DMA_Write_Start) wr_cnt = wr_cnt + 1;
    if (dp.pool_start)      ps_cnt = ps_cnt + 1;
    if (irq_done)           irq_cnt = irq_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command and check CFG, the pulse cycle and the cycle after it.
  task automatic start_layer(input logic [31:0] r7, input logic [11:0] exp_w, input logic [15:0] exp_cpp);
    Switch = 4'b1000; Reg_7 = r7; Control_RE = 8'h04;
    tick();
    Control_RE = 8'h00;
    tests_run++;
    if (State_RE !== 4'b0001 || dp.DMA_Read_Start !== 1'b0) begin
      tests_failed++; $display("FAIL cfg_cycle: State_RE=%b rd=%b expected 0001/0", State_RE, dp.DMA_Read_Start);
    end
    tick();
    tests_run++;
    if ({dp.DMA_Read_Start, dp.DMA_Write_Start, dp.pool_start} !== 3'b111) begin
      tests_failed++; $display("FAIL start_pulses: got %b expected 111", {dp.DMA_Read_Start, dp.DMA_Write_Start, dp.pool_start});
    end
    tests_run++;
    if (dp.pool_row_width !== exp_w || dp.pool_beats_per_pix !== exp_cpp) begin
      tests_failed++; $display("FAIL pool_cfg: w=%0d cpp=%0d expected %0d/%0d", dp.pool_row_width, dp.pool_beats_per_pix, exp_w, exp_cpp);
    end
    tick();
    tests_run++;
    if ({dp.DMA_Read_Start, dp.DMA_Write_Start, dp.pool_start} !== 3'b000) begin
      tests_failed++; $display("FAIL pulse_width: got %b expected 000", {dp.DMA_Read_Start, dp.DMA_Write_Start, dp.pool_start});
    end
  endtask

  // Drive output beats until `total` are accepted; DONE must appear exactly one edge later.
  task automatic run_out(input int total, input bit toggle);
    int acc = 0;
    int cyc = 0;
    bit early = 1'b0;
    bit r;
    int irq0;
    while (acc < total && cyc < 2 * total + 8) begin
      r = !toggle || (cyc % 2 == 0);
      dp.M_Valid = 1'b1; dp.M_Ready = r;
      tick();
      cyc++;
      if (r) acc++;
      if (State_RE !== 4'b0001) early = 1'b1;
    end
    dp.M_Valid = 1'b0; dp.M_Ready = 1'b0;
    tests_run++;
    if (acc !== total) begin
      tests_failed++; $display("FAIL beat_budget: accepted %0d expected %0d", acc, total);
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++; $display("FAIL early_done: left busy before %0d beats (got 1 expected 0)", total);
    end
    irq0 = irq_cnt;
    tick();
    tests_run++;
    if (State_RE !== 4'b1111 || irq_done !== 1'b1) begin
      tests_failed++; $display("FAIL done_entry: State_RE=%b irq=%b expected 1111/1", State_RE, irq_done);
    end
    tick();
    tests_run++;
    if (State_RE !== 4'b1111 || irq_cnt - irq0 !== 1) begin
      tests_failed++; $display("FAIL done_hold: State_RE=%b irq_pulses=%0d expected 1111/1", State_RE, irq_cnt - irq0);
    end
  endtask

  task automatic ack();
    Control_RE = 8'h0F;
    tick();
    Control_RE = 8'h00;
    tests_run++;
    if (State_RE !== 4'b0000) begin
      tests_failed++; $display("FAIL ack_idle: State_RE=%b expected 0000", State_RE);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run++;
    if ({State_RE, irq_done, dp.DMA_Read_Start, dp.DMA_Write_Start, dp.pool_start} !== 8'h00 ||
        dp.pool_row_width !== 12'd0 || dp.pool_beats_per_pix !== 16'd0) begin
      tests_failed++; $display("FAIL reset_outputs: State_RE=%b w=%0d cpp=%0d expected all 0", State_RE, dp.pool_row_width, dp.pool_beats_per_pix);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_layer_w26();
    dp.S_Valid = 1'b1; dp.S_Ready = 1'b1;
    start_layer(32'h0010_001A, 12'd26, 16'd32);
    run_out(5408, 1'b0);
    dp.S_Valid = 1'b0; dp.S_Ready = 1'b0;
  endtask

  task automatic test_ack_restart();
    ack();
    start_layer(32'h0001_0004, 12'd4, 16'd2);
    run_out(8, 1'b0);
    ack();
  endtask

  task automatic test_toggle_ready();
    start_layer(32'h0004_0068, 12'd104, 16'd8);
    run_out(21632, 1'b1);
    ack();
  endtask

  task automatic test_config_errors();
    logic [31:0] bad_cfg [3];
    int rd0, wr0, irq0;
    bad_cfg[0] = 32'h0010_0019;
    bad_cfg[1] = 32'h0010_0000;
    bad_cfg[2] = 32'h0000_001A;
    for (int i = 0; i < 3; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt; irq0 = irq_cnt;
      Switch = 4'b1000; Reg_7 = bad_cfg[i]; Control_RE = 8'h04;
      tick();
      Control_RE = 8'h00;
      tick();
      tests_run++;
      if (State_RE !== 4'b1110 || irq_done !== 1'b1) begin
        tests_failed++; $display("FAIL err_entry[%0d]: State_RE=%b irq=%b expected 1110/1", i, State_RE, irq_done);
      end
      tick(); tick();
      tests_run++;
      if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0 || irq_cnt - irq0 !== 1 || State_RE !== 4'b1110) begin
        tests_failed++; $display("FAIL err_pulses[%0d]: rd=%0d wr=%0d irq=%0d st=%b expected 0/0/1/1110", i, rd_cnt - rd0, wr_cnt - wr0, irq_cnt - irq0, State_RE);
      end
      ack();
    end
  endtask

  task automatic test_ignored_cmds();
    int rd0;
    rd0 = rd_cnt;
    Switch = 4'b0001; Reg_7 = 32'h0001_0004; Control_RE = 8'h04;
    repeat (3) tick();
    Control_RE = 8'h00;
    tick();
    tests_run++;
    if (State_RE !== 4'b0000 || rd_cnt - rd0 !== 0) begin
      tests_failed++; $display("FAIL wrong_switch: State_RE=%b rd_pulses=%0d expected 0000/0", State_RE, rd_cnt - rd0);
    end
    Control_RE = 8'h0F;
    tick();
    Control_RE = 8'h00;
    tests_run++;
    if (State_RE !== 4'b0000) begin
      tests_failed++; $display("FAIL ack_in_idle: State_RE=%b expected 0000", State_RE);
    end
    start_layer(32'h0001_0004, 12'd4, 16'd2);
    Control_RE = 8'h0F; Switch = 4'b0000;
    repeat (3) tick();
    Control_RE = 8'h00;
    tests_run++;
    if (State_RE !== 4'b0001) begin
      tests_failed++; $display("FAIL ack_in_run: State_RE=%b expected 0001", State_RE);
    end
    run_out(8, 1'b0);
    ack();
  endtask

  task automatic test_reset_mid_run();
    start_layer(32'h0010_001A, 12'd26, 16'd32);
    for (int i = 0; i < 1000; i++) begin
      dp.M_Valid = 1'b1; dp.M_Ready = 1'b1;
      tick();
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({State_RE, irq_done, dp.DMA_Read_Start, dp.DMA_Write_Start, dp.pool_start} !== 8'h00 ||
        dp.pool_row_width !== 12'd0 || dp.pool_beats_per_pix !== 16'd0) begin
      tests_failed++; $display("FAIL async_reset: State_RE=%b w=%0d cpp=%0d expected all 0", State_RE, dp.pool_row_width, dp.pool_beats_per_pix);
    end
    dp.M_Valid = 1'b0; dp.M_Ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_layer(32'h0010_001A, 12'd26, 16'd32);
    run_out(5408, 1'b0);
    ack();
  endtask

  initial begin
    dp.S_Valid = 1'b0; dp.S_Ready = 1'b0; dp.M_Valid = 1'b0; dp.M_Ready = 1'b0;
    test_reset();
    test_layer_w26();
    test_ack_restart();
    test_toggle_ready();
    test_config_errors();
    test_ignored_cmds();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
